// File: rtl/cnn_window_buffer_if.sv
// Handshake bundle between the pixel source, cnn_window_buffer and the window consumer.
interface cnn_window_buffer_if #(
  parameter int DW = 16,
  parameter int K  = 7
);
  logic [DW-1:0]     pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [DW*K*K-1:0] win_out;
  logic              win_valid;
  logic              win_ready;
  logic              frame_done;

  modport master (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win_out, win_valid, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win_out, win_valid, frame_done
  );
endinterface

// File: rtl/cnn_window_buffer.sv
// Streaming K x K window builder over K-1 line memories; raster-order pixels in, flat windows out.
// Optional macro CNN_WINBUF_STRIDE2_EN emits only every second window in both directions.
module cnn_window_buffer #(
  parameter int DW    = 16,
  parameter int K     = 7,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  cnn_window_buffer_if.slave bus
);
  localparam int WW = DW * K * K;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] win_q, win_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          accept_s;
  logic          complete_s;
  logic [CW-1:0] col_off_s;
  logic [RW-1:0] row_off_s;

  // Line memories: row 0 holds the oldest line, row K-2 the line just above the incoming pixel.
  logic [DW-1:0] lmem_q [0:K-2][0:IMG_W-1];

  assign accept_s      = bus.pix_valid && bus.pix_ready;
  assign bus.pix_ready = !win_valid_q || bus.win_ready;
  assign bus.win_out   = win_q;
  assign bus.win_valid = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign col_off_s     = col_q - COL_FIRST;
  assign row_off_s     = row_q - ROW_FIRST;

  // Decide whether the pixel at (row_q, col_q) closes an emitted window.
  always_comb begin
    complete_s = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
`ifdef CNN_WINBUF_STRIDE2_EN
    if ((row_off_s[0] != 1'b0) || (col_off_s[0] != 1'b0)) begin
      complete_s = 1'b0;
    end else begin
      complete_s = complete_s;
    end
`endif
  end

  // Raster position counters and the frame-end pulse.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    if (accept_s) begin
      if (col_q == COL_LAST) begin
        col_d = {CW{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d        = {RW{1'b0}};
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // Window shift: drop the left column, append the line-memory column plus the new pixel.
  always_comb begin
    win_d = win_q;
    if (accept_s) begin
      for (int j = 0; j < K; j++) begin
        for (int i = 0; i < K - 1; i++) begin
          win_d[(K*j+i)*DW +: DW] = win_q[(K*j+i+1)*DW +: DW];
        end
      end
      for (int j = 0; j < K - 1; j++) begin
        win_d[(K*j+K-1)*DW +: DW] = lmem_q[j][col_q];
      end
      win_d[(K*(K-1)+K-1)*DW +: DW] = bus.pix_in;
    end else begin
      win_d = win_q;
    end
  end

  // Output valid: load on a completing accept, otherwise clear once the consumer takes it.
  always_comb begin
    win_valid_d = win_valid_q;
    if (accept_s && complete_s) begin
      win_valid_d = 1'b1;
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      win_q        <= {WW{1'b0}};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line-memory column rotation; contents are don't-care until K-1 lines have streamed in.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int r = 0; r < K - 2; r++) begin
        lmem_q[r][col_q] <= lmem_q[r+1][col_q];
      end
      lmem_q[K-2][col_q] <= bus.pix_in;
    end
  end
endmodule

// File: tb/tb_cnn_window_buffer.sv
// Directed bench for cnn_window_buffer: ramp frames, backpressure, back-to-back frames, mid-frame reset.
module tb_cnn_window_buffer;
  localparam int DW = 16, K = 7, IMG_W = 28, IMG_H = 28;
  localparam int WW = DW * K * K;
  localparam int NPIX = IMG_W * IMG_H;
`ifdef CNN_WINBUF_STRIDE2_EN
  localparam int WPF = 121;
`else
  localparam int WPF = 484;
`endif

  typedef struct {
    int win_idx;
    int row;
    int col;
    int expv;
  } vec_t;

  logic clk;
  logic rst_n;
  cnn_window_buffer_if #(.DW(DW), .K(K)) bus ();

  cnn_window_buffer #(.DW(DW), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int m_r = 0, m_c = 0;
  int win_cnt, acc_total, first_win_acc;
  bit fd_exp = 1'b0;
  int exp_q[$];
  int fd_acc[$];
  logic [WW-1:0] got_q[$];

  task automatic chk(input string nm, input longint got, input longint expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  function automatic int elem(input logic [WW-1:0] w, input int j, input int i);
    return int'(w[(K*j+i)*DW +: DW]);
  endfunction

  task automatic chk_win(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      for (int e = 0; e < K * K; e++) begin
        if (elem(got, e / K, e % K) != elem(expv, e / K, e % K)) begin
          $display("FAIL %s: element (%0d,%0d) got %0d expected %0d", nm, e / K, e % K,
                   elem(got, e / K, e % K), elem(expv, e / K, e % K));
          break;
        end
      end
    end
  endtask

  // Expected window closed by ramp pixel index p (value of pixel (r,c) is IMG_W*r+c).
  function automatic logic [WW-1:0] model_win(input int p);
    int r, c;
    logic [WW-1:0] w;
    r = p / IMG_W;
    c = p % IMG_W;
    w = '0;
    for (int j = 0; j < K; j++)
      for (int i = 0; i < K; i++)
        w[(K*j+i)*DW +: DW] = DW'((r - K + 1 + j) * IMG_W + (c - K + 1 + i));
    return w;
  endfunction

  function automatic bit is_complete(input int r, input int c);
    bit ok;
    ok = (r >= K - 1) && (c >= K - 1);
`ifdef CNN_WINBUF_STRIDE2_EN
    ok = ok && (((r - (K - 1)) % 2) == 0) && (((c - (K - 1)) % 2) == 0);
`endif
    return ok;
  endfunction

  // Stream npix ramp pixels, consuming every window; stall the consumer 5 cycles at window bp_at.
  task automatic stream(input int npix, input int bp_at);
    int sent = 0;
    int cyc = 0;
    bit bp_done = 1'b0;
    bit acc;
    logic [WW-1:0] hold;
    win_cnt = 0; acc_total = 0; first_win_acc = -1;
    got_q.delete(); fd_acc.delete(); exp_q.delete();
    while (sent < npix || exp_q.size() > 0) begin
      cyc++;
      if (cyc > 2 * npix + 100) begin
        n_chk++; n_fail++;
        $display("FAIL stream_timeout: got %0d accepts expected %0d", sent, npix);
        break;
      end
      @(negedge clk);
      chk("frame_done", bus.frame_done, fd_exp);
      bus.pix_valid = (sent < npix);
      bus.pix_in    = DW'(m_r * IMG_W + m_c);
      bus.win_ready = 1'b1;
      #1;
      chk("win_valid", bus.win_valid, exp_q.size() != 0);
      if (bp_at >= 0 && !bp_done && bus.win_valid && win_cnt == bp_at) begin
        bp_done = 1'b1;
        hold = bus.win_out;
        bus.win_ready = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
          chk("stall_pix_ready", bus.pix_ready, 0);
          @(posedge clk);
          #1;
          chk("stall_win_valid", bus.win_valid, 1);
          chk_win("stall_win_out", bus.win_out, hold);
        end
        fd_exp = 1'b0;
        continue;
      end
      chk("pix_ready", bus.pix_ready, 1);
      acc = bus.pix_valid && bus.pix_ready;
      if (bus.win_valid) begin
        if (exp_q.size() != 0) chk_win("win_out", bus.win_out, model_win(exp_q.pop_front()));
        got_q.push_back(bus.win_out);
        win_cnt++;
      end
      @(posedge clk);
      if (acc) begin
        if (is_complete(m_r, m_c)) begin
          exp_q.push_back(m_r * IMG_W + m_c);
          if (first_win_acc < 0) first_win_acc = acc_total;
        end
        fd_exp = (m_r == IMG_H - 1) && (m_c == IMG_W - 1);
        if (fd_exp) fd_acc.push_back(acc_total);
        m_c++;
        if (m_c == IMG_W) begin
          m_c = 0;
          m_r = (m_r == IMG_H - 1) ? 0 : m_r + 1;
        end
        sent++;
        acc_total++;
      end else begin
        fd_exp = 1'b0;
      end
    end
    @(negedge clk);
    chk("frame_done_tail", bus.frame_done, fd_exp);
    fd_exp = 1'b0;
    bus.pix_valid = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
`ifdef CNN_WINBUF_STRIDE2_EN
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{0, 3, 2, 86};
    tbl[2] = '{0, 6, 6, 174};
    tbl[3] = '{1, 0, 0, 2};
    tbl[4] = '{11, 0, 0, 56};
    tbl[5] = '{120, 6, 6, 754};
`else
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{0, 3, 2, 86};
    tbl[2] = '{0, 6, 6, 174};
    tbl[3] = '{1, 0, 0, 1};
    tbl[4] = '{22, 0, 0, 28};
    tbl[5] = '{483, 6, 6, 783};
`endif

    // Reset with random inputs toggling.
    rst_n = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      bus.pix_in    = DW'($urandom);
      bus.pix_valid = $urandom_range(0, 1) == 1;
      bus.win_ready = $urandom_range(0, 1) == 1;
      #1;
      chk("rst_win_valid", bus.win_valid, 0);
      chk("rst_win_out_zero", bus.win_out == '0, 1);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_pix_ready", bus.pix_ready, 1);
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b1;
    rst_n = 1'b1;

    // Single ramp frame, consumer always ready.
    stream(NPIX, -1);
    chk("f1_win_count", win_cnt, WPF);
    chk("f1_fd_count", fd_acc.size(), 1);
    chk("f1_first_win_acc", first_win_acc, 174);
    for (int v = 0; v < 6; v++) begin
      if (tbl[v].win_idx < got_q.size())
        chk($sformatf("tbl%0d_elem", v), elem(got_q[tbl[v].win_idx], tbl[v].row, tbl[v].col), tbl[v].expv);
      else
        chk($sformatf("tbl%0d_present", v), got_q.size(), tbl[v].win_idx + 1);
    end

    // Two frames back to back with a consumer stall.
    stream(2 * NPIX, 10);
    chk("b2b_win_count", win_cnt, 2 * WPF);
    chk("b2b_fd_count", fd_acc.size(), 2);
    if (fd_acc.size() == 2) begin
      chk("b2b_fd0_acc", fd_acc[0], NPIX - 1);
      chk("b2b_fd_spacing", fd_acc[1] - fd_acc[0], NPIX);
    end
    if (got_q.size() > WPF) chk_win("b2b_first_win_repeat", got_q[WPF], got_q[0]);

    // Reset mid-frame after 100 accepts, then restart the ramp.
    stream(100, -1);
    chk("mid_no_win", win_cnt, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_win_valid", bus.win_valid, 0);
    chk("mid_rst_win_out_zero", bus.win_out == '0, 1);
    chk("mid_rst_frame_done", bus.frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_r = 0;
    m_c = 0;
    stream(NPIX, -1);
    chk("mid_first_win_acc", first_win_acc, 174);
    chk("mid_win_count", win_cnt, WPF);
    if (got_q.size() > 0) chk("mid_first_elem00", elem(got_q[0], 0, 0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
